// File: rtl/bytecode_fetch_pkg.sv
// Bytecode fetch shared definitions: issue FSM encoding,
// address width and the operand-bearing opcode set.
package bytecode_fetch_pkg;

  localparam int ADDR_W = 16;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_OPERAND   = 2'd1;
  localparam logic [1:0] S_ISSUE     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [7:0] OPC_OPND_A  = 8'h10;
  localparam logic [7:0] OPC_OPND_B  = 8'h12;
  localparam logic [7:0] OPC_RUN1_LO = 8'h15;
  localparam logic [7:0] OPC_RUN1_HI = 8'h19;
  localparam logic [7:0] OPC_RUN2_LO = 8'h36;
  localparam logic [7:0] OPC_RUN2_HI = 8'h3A;

  function automatic logic has_operand(input logic [7:0] op);
    return (op == OPC_OPND_A) || (op == OPC_OPND_B) ||
           ((op >= OPC_RUN1_LO) && (op <= OPC_RUN1_HI)) ||
           ((op >= OPC_RUN2_LO) && (op <= OPC_RUN2_HI));
  endfunction

endpackage

// File: rtl/bytecode_fetch_byte_fifo.sv
// Byte-wide prefetch FIFO with same-cycle push/pop
// and a synchronous flush that empties it.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    ram [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout  = ram[rd_ptr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (push && !flush) ram[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bytecode_fetch.sv
// Bytecode prefetcher: single-outstanding byte fetch into a FIFO
// and an issue FSM handing {operand, opcode} to the decoder.
module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDR_W     = bytecode_fetch_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic              start,
  input  logic              ready,
  output logic [15:0]       instruction_in,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] head_addr;
  logic              discard;
  logic              inflight;
  logic              fetch_ok;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic [7:0]        dout;
  logic              can_take;
  logic              take_op;
  logic              take_opnd;

  assign mem_addr = fetch_addr;
  assign inflight = mem_req | discard;
  assign fetch_ok = run & ~inflight & ~full &
                    ((count + CW'(inflight)) < DEPTH_C);
  assign push     = mem_req & mem_valid & ~pc_load;

  assign can_take  = (state == S_IDLE) |
                     ((state == S_WAIT_DONE) & ready);
  assign take_op   = can_take & run & ready & ~empty & ~pc_load;
  assign take_opnd = (state == S_OPERAND) & ~empty & ~pc_load;
  assign pop       = take_op | take_opnd;

  assign start = state == S_ISSUE;
  assign busy  = state != S_IDLE;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (pc_load),
    .din   (mem_rdata),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // A response still owed after a redirect is swallowed by discard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      fetch_addr <= '0;
      discard    <= 1'b0;
    end else if (pc_load) begin
      mem_req    <= 1'b0;
      fetch_addr <= pc_value;
      discard    <= inflight & ~mem_valid;
    end else begin
      if (discard && mem_valid) discard <= 1'b0;
      if (push) begin
        mem_req    <= 1'b0;
        fetch_addr <= fetch_addr + ADDR_W'(1);
      end else if (fetch_ok) begin
        mem_req <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      instruction_in <= '0;
      pc             <= '0;
      head_addr      <= '0;
    end else begin
      if (pc_load)  head_addr <= pc_value;
      else if (pop) head_addr <= head_addr + ADDR_W'(1);
      if (take_op) begin
        pc             <= head_addr;
        instruction_in <= {8'h00, dout};
        state          <= has_operand(dout) ? S_OPERAND : S_ISSUE;
      end else begin
        unique case (1'b1)
          state == S_OPERAND: begin
            if (pc_load) begin
              state <= S_IDLE;
            end else if (take_opnd) begin
              instruction_in[15:8] <= dout;
              state                <= S_ISSUE;
            end
          end
          state == S_ISSUE: begin
            if (!ready) state <= S_WAIT_DONE;
          end
          state == S_WAIT_DONE: begin
            if (ready) state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Directed bench for bytecode_fetch with a latency-programmable
// byte memory and a simple handshaking decoder model.
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic        start;
  logic        ready;
  logic [15:0] instruction_in;
  logic [15:0] pc;
  logic        busy;

  always #5 clk = ~clk;

  bytecode_fetch #(
    .ADDR_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .pc_load        (pc_load),
    .pc_value       (pc_value),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_valid      (mem_valid),
    .start          (start),
    .ready          (ready),
    .instruction_in (instruction_in),
    .pc             (pc),
    .busy           (busy)
  );

  int tests;
  int fails;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model
  logic [7:0]  mem [65536];
  int          slow_addr;
  int          slow_lat;
  bit          pend;
  int          mcnt;
  logic [15:0] paddr;
  int          req_count;
  logic [15:0] req_log [$];

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      pend      = 1'b0;
      mem_valid = 1'b0;
    end else begin
      if (mem_valid) begin
        mem_valid = 1'b0;
        pend      = 1'b0;
      end
      if (pend) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem[paddr];
        end
      end else if (mem_req) begin
        pend  = 1'b1;
        paddr = mem_addr;
        mcnt  = (int'(mem_addr) == slow_addr) ? slow_lat : 1;
        req_count++;
        req_log.push_back(mem_addr);
      end
    end
  end

  // decoder model: ready low for 2 cycles per accepted instruction
  bit          accept_en;
  int          dcnt;
  int          cyc;
  logic [15:0] log_pc  [$];
  logic [15:0] log_ins [$];
  int          log_cyc [$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset) begin
      ready = 1'b1;
      dcnt  = 0;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) ready = 1'b1;
    end else if (start && ready && accept_en) begin
      log_pc.push_back(pc);
      log_ins.push_back(instruction_in);
      log_cyc.push_back(cyc);
      ready = 1'b0;
      dcnt  = 2;
    end
  end

  task automatic do_reset(input logic [7:0] fill);
    @(negedge clk);
    reset     = 1'b0;
    run       = 1'b0;
    pc_load   = 1'b0;
    accept_en = 1'b1;
    slow_addr = -1;
    slow_lat  = 1;
    for (int i = 0; i < 65536; i++) mem[i] = fill;
    log_pc.delete();
    log_ins.delete();
    log_cyc.delete();
    req_log.delete();
    req_count = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    run       = 1'b0;
    pc_load   = 1'b0;
    pc_value  = '0;
    ready     = 1'b1;
    mem_valid = 1'b0;
    mem_rdata = '0;
    accept_en = 1'b1;
    slow_addr = -1;
    slow_lat  = 1;
    req_count = 0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_instr", instruction_in, 0);
    check("rst_pc", pc, 0);

    // two plain opcodes, back-to-back handshakes
    do_reset(8'h00);
    mem[0] = 8'h03;
    mem[1] = 8'h60;
    run = 1'b1;
    wait_cycles(30);
    check("a_n_issued", log_pc.size() >= 2, 1);
    if (log_pc.size() >= 2) begin
      check("a_ins0", log_ins[0], 16'h0003);
      check("a_pc0", log_pc[0], 16'h0000);
      check("a_ins1", log_ins[1], 16'h0060);
      check("a_pc1", log_pc[1], 16'h0001);
      check("a_spacing", log_cyc[1] - log_cyc[0], 3);
    end

    // operand opcode with a late operand byte
    do_reset(8'h00);
    mem[0]    = 8'h10;
    mem[1]    = 8'h7F;
    slow_addr = 1;
    slow_lat  = 6;
    run = 1'b1;
    for (int i = 0; i < 50 && !busy; i++) wait_cycles(1);
    check("b_busy_rise", busy, 1);
    wait_cycles(2);
    check("b_hold_start", start, 0);
    check("b_hold_busy", busy, 1);
    check("b_hold_instr", instruction_in, 16'h0010);
    wait_cycles(30);
    check("b_n_issued", log_pc.size() >= 2, 1);
    if (log_pc.size() >= 2) begin
      check("b_ins0", log_ins[0], 16'h7F10);
      check("b_pc0", log_pc[0], 16'h0000);
      check("b_pc1", log_pc[1], 16'h0002);
    end

    // decoder never accepts
    do_reset(8'h00);
    mem[0]    = 8'h05;
    accept_en = 1'b0;
    run = 1'b1;
    wait_cycles(60);
    check("c_start", start, 1);
    check("c_instr", instruction_in, 16'h0005);
    check("c_reqs", req_count, 5);
    check("c_req_idle", mem_req, 0);
    wait_cycles(20);
    check("c_start_late", start, 1);
    check("c_instr_late", instruction_in, 16'h0005);
    check("c_reqs_late", req_count, 5);

    // redirect while a request is outstanding
    do_reset(8'h01);
    mem[4]      = 8'hEE;
    mem[16'h100] = 8'h22;
    mem[16'h101] = 8'h33;
    slow_addr = 4;
    slow_lat  = 8;
    accept_en = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 100 && !(mem_req && mem_addr == 16'h0004); i++)
      wait_cycles(1);
    check("d_req4", mem_req && mem_addr == 16'h0004, 1);
    pc_value = 16'h0100;
    pc_load  = 1'b1;
    wait_cycles(1);
    pc_load = 1'b0;
    check("d_req_drop", mem_req, 0);
    check("d_start_kept", start, 1);
    accept_en = 1'b1;
    wait_cycles(60);
    check("d_n_issued", log_pc.size() >= 3, 1);
    if (log_pc.size() >= 3) begin
      check("d_pc0", log_pc[0], 16'h0000);
      check("d_pc1", log_pc[1], 16'h0100);
      check("d_ins1", log_ins[1], 16'h0022);
      check("d_pc2", log_pc[2], 16'h0101);
      check("d_ins2", log_ins[2], 16'h0033);
    end

    // address wrap
    do_reset(8'h00);
    mem[16'hFFFF] = 8'h01;
    mem[0]        = 8'h02;
    pc_value = 16'hFFFF;
    pc_load  = 1'b1;
    wait_cycles(1);
    pc_load = 1'b0;
    run = 1'b1;
    wait_cycles(30);
    check("e_n_reqs", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) begin
      check("e_req0", req_log[0], 16'hFFFF);
      check("e_req1", req_log[1], 16'h0000);
    end
    check("e_n_issued", log_pc.size() >= 2, 1);
    if (log_pc.size() >= 2) begin
      check("e_pc0", log_pc[0], 16'hFFFF);
      check("e_ins0", log_ins[0], 16'h0001);
      check("e_pc1", log_pc[1], 16'h0000);
      check("e_ins1", log_ins[1], 16'h0002);
    end

    // reset during WAIT_DONE
    do_reset(8'h00);
    run = 1'b1;
    for (int i = 0; i < 50 && !start; i++) wait_cycles(1);
    check("f_start_seen", start, 1);
    wait_cycles(1);
    check("f_wait_busy", busy, 1);
    check("f_wait_start", start, 0);
    #2 reset = 1'b0;
    #1;
    check("f_rst_start", start, 0);
    check("f_rst_req", mem_req, 0);
    check("f_rst_busy", busy, 0);
    check("f_rst_instr", instruction_in, 0);
    run = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_cycles(3);
    check("f_fifo_count", dut.u_fifo.count, 0);
    check("f_fifo_empty", dut.u_fifo.empty, 1);
    check("f_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
